// File: rtl/player_ctrl_pkg.sv
// Shared game parameters for the player controller: map size, direction
// encoding, controller state encoding and small helpers.
package player_ctrl_pkg;

    // Playable map size in tiles. Coordinates are 4 bits wide.
    localparam int MAP_WIDTH  = 13;
    localparam int MAP_HEIGHT = 15;

    // Direction encoding shared with the interaction stage.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    // Controller states (kept as plain constants for older consumers).
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ASK  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    // Key vectors are packed as {up, down, left, right}; up wins.
    function automatic dir_e prio_dir(input logic [3:0] keys);
        if (keys[3]) begin
            return DIR_UP;
        end else if (keys[2]) begin
            return DIR_DOWN;
        end else if (keys[1]) begin
            return DIR_LEFT;
        end else begin
            return DIR_RIGHT;
        end
    endfunction

endpackage

// File: rtl/player_ctrl_key_repeat.sv
// Direction-key front end: rising-edge detect, up>down>left>right priority
// and hold-to-repeat. Emits a registered one-cycle dir_valid with its dir.
module key_repeat
    import player_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES   = 40_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_up,
    input  logic key_down,
    input  logic key_left,
    input  logic key_right,
    output logic dir_valid,
    output dir_e dir
);

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [3:0]    keys;
    logic [3:0]    key_hist;
    logic [3:0]    rise;
    logic [CW-1:0] rep_cnt;
    logic          repeating;   // first hold period already elapsed
    logic          tick;

    assign keys = {key_up, key_down, key_left, key_right};
    assign rise = keys & ~key_hist;

    // Repeat tick: counter reaches the hold length first, then the repeat length.
    assign tick = (|keys) && !(|rise) &&
                  (repeating ? (rep_cnt == REP_LAST) : (rep_cnt == HOLD_LAST));

    // Key history, repeat counter and the registered direction event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            key_hist  <= 4'b0000;
            rep_cnt   <= '0;
            repeating <= 1'b0;
            dir_valid <= 1'b0;
            dir       <= DIR_UP;
        end else begin
            key_hist <= keys;
            if ((|rise) || !(|keys)) begin
                rep_cnt   <= '0;
                repeating <= 1'b0;
            end else if (tick) begin
                rep_cnt   <= '0;
                repeating <= 1'b1;
            end else begin
                rep_cnt <= rep_cnt + CNT_ONE;
            end
            dir_valid <= (|rise) || tick;
            dir       <= (|rise) ? prio_dir(rise) : prio_dir(keys);
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Player movement controller: turns direction events into one-tile move
// requests, holds the request until the interaction stage answers or the
// wait times out, and owns the committed player-state registers.
//
// Handshake: player_ask_move is high for exactly one cycle (ASK) with
// player_ask_x/y valid; the interaction stage answers with a one-cycle
// accept_move carrying goto_x/y, floor_in, key_num_in, health_in, which is
// only honoured while waiting. player_ask_x/y and the committed outputs stay
// stable from the request until the commit or timeout.
module player_ctrl
    import player_ctrl_pkg::*;
#(
    parameter int START_X        = 6,
    parameter int START_Y        = 11,
    parameter int START_FLOOR    = 0,
    parameter int START_HEALTH   = 1000,
    parameter int START_KEYS     = 0,
    parameter int HOLD_CYCLES    = 40_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        accept_move,
    input  logic [3:0]  goto_x,
    input  logic [3:0]  goto_y,
    input  logic [15:0] floor_in,
    input  logic [3:0]  key_num_in,
    input  logic [15:0] health_in,
    output logic        player_ask_move,
    output logic [3:0]  player_ask_x,
    output logic [3:0]  player_ask_y,
    output logic [3:0]  player_x,
    output logic [3:0]  player_y,
    output logic [15:0] floor,
    output logic [3:0]  key_num,
    output logic [15:0] health,
    output logic        busy,
    output logic        move_timeout,
    output logic [1:0]  fsm_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_ONE  = TW'(1);

    logic [1:0]    state;
    logic [TW-1:0] to_cnt;
    logic          dir_valid;
    dir_e          dir;
    logic [4:0]    tgt_x;
    logic [4:0]    tgt_y;
    logic          tgt_ok;

    key_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_key_repeat (
        .clk       (clk),
        .rstn      (rstn),
        .key_up    (key_up),
        .key_down  (key_down),
        .key_left  (key_left),
        .key_right (key_right),
        .dir_valid (dir_valid),
        .dir       (dir)
    );

    assign busy            = (state != S_IDLE);
    assign player_ask_move = (state == S_ASK);
    assign fsm_state       = state;

    // Target tile as a 5-bit signed value; bit 4 set means off the map edge.
    always_comb begin
        tgt_x = {1'b0, player_x};
        tgt_y = {1'b0, player_y};
        case (dir)
            DIR_UP:    tgt_y = {1'b0, player_y} - 5'd1;
            DIR_DOWN:  tgt_y = {1'b0, player_y} + 5'd1;
            DIR_LEFT:  tgt_x = {1'b0, player_x} - 5'd1;
            default:   tgt_x = {1'b0, player_x} + 5'd1;
        endcase
        tgt_ok = !tgt_x[4] && !tgt_y[4] &&
                 (tgt_x < 5'(MAP_WIDTH)) && (tgt_y < 5'(MAP_HEIGHT));
    end

    // Request FSM with timeout counter and committed player state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            move_timeout <= 1'b0;
            player_ask_x <= 4'(START_X);
            player_ask_y <= 4'(START_Y);
            player_x     <= 4'(START_X);
            player_y     <= 4'(START_Y);
            floor        <= 16'(START_FLOOR);
            key_num      <= 4'(START_KEYS);
            health       <= 16'(START_HEALTH);
        end else begin
            move_timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Events arriving while busy were simply never seen here.
                    if (dir_valid && (health != 16'd0) && tgt_ok) begin
                        state        <= S_ASK;
                        player_ask_x <= tgt_x[3:0];
                        player_ask_y <= tgt_y[3:0];
                    end
                end
                S_ASK: begin
                    state  <= S_WAIT;
                    to_cnt <= '0;
                end
                S_WAIT: begin
                    // An accept on the last waiting cycle still wins.
                    if (accept_move) begin
                        state    <= S_IDLE;
                        player_x <= goto_x;
                        player_y <= goto_y;
                        floor    <= floor_in;
                        key_num  <= key_num_in;
                        health   <= health_in;
                    end else if (to_cnt == TO_LAST) begin
                        state        <= S_IDLE;
                        move_timeout <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus randomized key/accept
// traffic, with an event-level reference model checked every cycle.
module tb_player_ctrl;
  import player_ctrl_pkg::*;

  localparam int TB_HOLD   = 20;
  localparam int TB_REPEAT = 8;
  localparam int TB_TO     = 15;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        key_up, key_down, key_left, key_right;
  logic        accept_move;
  logic [3:0]  goto_x, goto_y, key_num_in;
  logic [15:0] floor_in, health_in;
  logic        player_ask_move, busy, move_timeout;
  logic [3:0]  player_ask_x, player_ask_y, player_x, player_y, key_num;
  logic [15:0] floor, health;
  logic [1:0]  fsm_state;

  player_ctrl #(
    .HOLD_CYCLES    (TB_HOLD),
    .REPEAT_CYCLES  (TB_REPEAT),
    .TIMEOUT_CYCLES (TB_TO)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .key_up          (key_up),
    .key_down        (key_down),
    .key_left        (key_left),
    .key_right       (key_right),
    .accept_move     (accept_move),
    .goto_x          (goto_x),
    .goto_y          (goto_y),
    .floor_in        (floor_in),
    .key_num_in      (key_num_in),
    .health_in       (health_in),
    .player_ask_move (player_ask_move),
    .player_ask_x    (player_ask_x),
    .player_ask_y    (player_ask_y),
    .player_x        (player_x),
    .player_y        (player_y),
    .floor           (floor),
    .key_num         (key_num),
    .health          (health),
    .busy            (busy),
    .move_timeout    (move_timeout),
    .fsm_state       (fsm_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  int          m_edge, m_hold_ref, m_req;
  logic [3:0]  m_prev, m_k, m_rise;
  logic        m_ev, m_nv, m_active;
  int          m_ev_dir, m_nd, m_el, m_tx, m_ty;
  logic [3:0]  e_ax, e_ay, e_px, e_py, e_keys;
  logic [15:0] e_floor, e_health;
  logic        e_ask, e_to;

  function automatic int first_dir(input logic [3:0] m);
    if (m[3]) return 0;
    if (m[2]) return 1;
    if (m[1]) return 2;
    return 3;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_edge = 0; m_hold_ref = 0; m_req = 0;
      m_prev = 4'b0; m_ev = 1'b0; m_ev_dir = 0; m_active = 1'b0;
      e_ax = 4'd6; e_ay = 4'd11; e_px = 4'd6; e_py = 4'd11;
      e_floor = 16'd0; e_keys = 4'd0; e_health = 16'd1000;
      e_ask = 1'b0; e_to = 1'b0;
    end else begin
      m_edge++;
      // key events seen at this edge
      m_k = {key_up, key_down, key_left, key_right};
      m_rise = m_k & ~m_prev;
      m_nv = 1'b0; m_nd = 0;
      if (m_rise != 4'b0) begin
        m_nv = 1'b1; m_nd = first_dir(m_rise); m_hold_ref = m_edge;
      end else if (m_k != 4'b0) begin
        m_el = m_edge - m_hold_ref;
        if (m_el == TB_HOLD || (m_el > TB_HOLD && ((m_el - TB_HOLD) % TB_REPEAT) == 0)) begin
          m_nv = 1'b1; m_nd = first_dir(m_k);
        end
      end
      // request lifetime
      e_ask = 1'b0; e_to = 1'b0;
      if (m_active) begin
        if (m_edge >= m_req + 2 && accept_move) begin
          e_px = goto_x; e_py = goto_y; e_floor = floor_in;
          e_keys = key_num_in; e_health = health_in;
          m_active = 1'b0;
        end else if (m_edge == m_req + 1 + TB_TO) begin
          e_to = 1'b1; m_active = 1'b0;
        end
      end else if (m_ev && e_health != 16'd0) begin
        m_tx = int'(e_px); m_ty = int'(e_py);
        case (m_ev_dir)
          0: m_ty = m_ty - 1;
          1: m_ty = m_ty + 1;
          2: m_tx = m_tx - 1;
          default: m_tx = m_tx + 1;
        endcase
        if (m_tx >= 0 && m_tx < MAP_WIDTH && m_ty >= 0 && m_ty < MAP_HEIGHT) begin
          m_active = 1'b1; m_req = m_edge; e_ask = 1'b1;
          e_ax = 4'(m_tx); e_ay = 4'(m_ty);
        end
      end
      m_ev = m_nv; m_ev_dir = m_nd; m_prev = m_k;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (rstn) begin
      check("ask_move", 16'(player_ask_move), 16'(e_ask));
      check("busy", 16'(busy), 16'(m_active));
      check("state_idle", 16'(fsm_state == S_IDLE), 16'(!m_active));
      check("move_timeout", 16'(move_timeout), 16'(e_to));
      check("ask_x", 16'(player_ask_x), 16'(e_ax));
      check("ask_y", 16'(player_ask_y), 16'(e_ay));
      check("player_x", 16'(player_x), 16'(e_px));
      check("player_y", 16'(player_y), 16'(e_py));
      check("floor", floor, e_floor);
      check("key_num", 16'(key_num), 16'(e_keys));
      check("health", health, e_health);
    end
  end

  // event counters used by the directed literal checks
  int ask_seen = 0;
  int to_seen  = 0;
  logic [3:0] last_ask_x, last_ask_y;
  always @(negedge clk) begin
    if (rstn) begin
      if (player_ask_move) begin
        ask_seen++; last_ask_x = player_ask_x; last_ask_y = player_ask_y;
      end
      if (move_timeout) to_seen++;
    end
  end

  // ---------------- interaction-stage responder ----------------
  int          acc_mode = 0;   // 0 never, 1 fixed latency, 2 random
  int          acc_cd = 0;
  logic [15:0] resp_health = 16'd1000;
  logic [15:0] resp_floor  = 16'd0;
  logic [3:0]  resp_keys   = 4'd0;

  always @(posedge clk) begin
    #2;
    case (acc_mode)
      1: begin
        if (acc_cd != 0) begin
          acc_cd--;
          accept_move = (acc_cd == 0);
        end else begin
          accept_move = 1'b0;
        end
        if (player_ask_move) acc_cd = 3;
      end
      2: begin
        accept_move = ($urandom_range(0, 5) == 0);
        acc_cd = 0;
      end
      default: begin
        accept_move = 1'b0;
        acc_cd = 0;
      end
    endcase
    goto_x = e_ax; goto_y = e_ay;
    health_in = resp_health; floor_in = resp_floor; key_num_in = resp_keys;
    if (acc_mode == 2) begin
      if ($urandom_range(0, 3) == 0) begin
        goto_x = 4'($urandom_range(0, MAP_WIDTH - 1));
        goto_y = 4'($urandom_range(0, MAP_HEIGHT - 1));
      end
      health_in  = (e_health > 16'd8) ? e_health - 16'($urandom_range(0, 3)) : e_health;
      floor_in   = 16'($urandom_range(0, 65535));
      key_num_in = 4'($urandom_range(0, 15));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] mask, input int hold, input int after);
    {key_up, key_down, key_left, key_right} = mask;
    repeat (hold) step();
    {key_up, key_down, key_left, key_right} = 4'b0000;
    repeat (after) step();
  endtask

  int a0, t0;

  initial begin
    rstn = 1'b0;
    {key_up, key_down, key_left, key_right} = 4'b0000;
    accept_move = 1'b0; goto_x = 4'd0; goto_y = 4'd0;
    floor_in = 16'd0; key_num_in = 4'd0; health_in = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_player_x", 16'(player_x), 16'd6);
    check("rst_player_y", 16'(player_y), 16'd11);
    check("rst_ask_x", 16'(player_ask_x), 16'd6);
    check("rst_ask_y", 16'(player_ask_y), 16'd11);
    check("rst_health", health, 16'd1000);
    check("rst_floor", floor, 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_ask_move", 16'(player_ask_move), 16'd0);
    rstn = 1'b1;
    step(); step();

    // single right pulse, accepted 3 cycles after the ask
    acc_mode = 1; resp_health = 16'd990;
    a0 = ask_seen;
    press(4'b0001, 1, 8);
    check("t1_asks", 16'(ask_seen - a0), 16'd1);
    check("t1_ask_x", 16'(last_ask_x), 16'd7);
    check("t1_ask_y", 16'(last_ask_y), 16'd11);
    check("t1_player_x", 16'(player_x), 16'd7);
    check("t1_health", health, 16'd990);

    // up and left together: up wins
    resp_health = 16'd985;
    a0 = ask_seen;
    press(4'b1010, 1, 8);
    check("t3_asks", 16'(ask_seen - a0), 16'd1);
    check("t3_ask_x", 16'(last_ask_x), 16'd7);
    check("t3_ask_y", 16'(last_ask_y), 16'd10);

    // walk to the left edge, then one more left is dropped
    for (int i = 0; i < 7; i++) press(4'b0010, 1, 8);
    check("t2_at_edge", 16'(player_x), 16'd0);
    a0 = ask_seen;
    press(4'b0010, 1, 10);
    check("t2_no_ask", 16'(ask_seen - a0), 16'd0);
    check("t2_busy", 16'(busy), 16'd0);

    // hold down: asks at +1, +21, +29, +37 then bottom edge stops it
    a0 = ask_seen;
    press(4'b0100, 60, 8);
    check("t4_asks", 16'(ask_seen - a0), 16'd4);
    check("t4_player_y", 16'(player_y), 16'd14);

    // no accept: timeout, no commit, next key still works
    acc_mode = 0; a0 = ask_seen; t0 = to_seen;
    press(4'b1000, 1, 25);
    check("t5_asks", 16'(ask_seen - a0), 16'd1);
    check("t5_timeouts", 16'(to_seen - t0), 16'd1);
    check("t5_player_y", 16'(player_y), 16'd14);
    check("t5_busy", 16'(busy), 16'd0);
    acc_mode = 1;
    press(4'b1000, 1, 8);
    check("t5_after_y", 16'(player_y), 16'd13);

    // randomized traffic
    acc_mode = 2;
    for (int s = 0; s < 60; s++) begin
      {key_up, key_down, key_left, key_right} =
        4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      repeat ($urandom_range(1, 50)) step();
    end
    {key_up, key_down, key_left, key_right} = 4'b0000;
    acc_mode = 0;
    repeat (20) step();

    // reset while waiting for acceptance
    resp_health = 16'd500; resp_floor = 16'd0; resp_keys = 4'd0;
    if (int'(e_px) + 1 < MAP_WIDTH) press(4'b0001, 1, 5);
    else press(4'b0010, 1, 5);
    check("t6_waiting", 16'(busy), 16'd1);
    rstn = 1'b0;
    #1;
    check("t6_player_x", 16'(player_x), 16'd6);
    check("t6_player_y", 16'(player_y), 16'd11);
    check("t6_health", health, 16'd1000);
    check("t6_busy", 16'(busy), 16'd0);
    check("t6_ask_x", 16'(player_ask_x), 16'd6);
    check("t6_timeout", 16'(move_timeout), 16'd0);
    step(); step();
    rstn = 1'b1;
    step();

    // commit zero health, then keys are ignored
    acc_mode = 1; resp_health = 16'd0;
    press(4'b1000, 1, 8);
    check("t7_health", health, 16'd0);
    check("t7_player_y", 16'(player_y), 16'd10);
    a0 = ask_seen;
    press(4'b1000, 1, 8);
    press(4'b0100, 1, 8);
    press(4'b0001, 30, 8);
    check("t7_no_ask", 16'(ask_seen - a0), 16'd0);
    check("t7_busy", 16'(busy), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_ctrl.md
# player_ctrl

Player movement controller sitting directly upstream of the tile-interaction stage. Turns direction-key levels into one-tile move requests with edge detection and hold-to-repeat, and holds the requested coordinates stable until the interaction stage answers. On acceptance it commits the returned position, floor, key count and health into the authoritative player-state registers that feed interaction, rendering and HUD.

## Interface
Parameters:
- START_X, 6: player x after reset
- START_Y, 11: player y after reset
- START_FLOOR, 0: floor after reset
- START_HEALTH, 1000: health after reset
- START_KEYS, 0: key count after reset
- HOLD_CYCLES, 40_000_000: cycles a key must stay held before the first auto-repeat
- REPEAT_CYCLES, 10_000_000: cycles between auto-repeats
- TIMEOUT_CYCLES, 15: cycles to wait for acceptance before abandoning a request

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- key_up, key_down, key_left, key_right  in  1 each  direction key levels, synchronous to clk
- accept_move  in  1  one-cycle acceptance pulse from interaction stage
- goto_x, goto_y  in  4 each  resulting player position
- floor_in  in  16  resulting floor
- key_num_in  in  4  resulting key count
- health_in  in  16  resulting health
- player_ask_move  out  1  one-cycle request pulse
- player_ask_x, player_ask_y  out  4 each  target tile, held while busy
- player_x, player_y  out  4 each  committed position
- floor  out  16  committed floor
- key_num  out  4  committed keys
- health  out  16  committed health
- busy  out  1  high when state is not IDLE
- move_timeout  out  1  one-cycle pulse when a request is abandoned

## Operation
- Direction select: a key is active on its rising edge, or on an auto-repeat tick while still held. Priority is up > down > left > right; at most one request per cycle.
- Repeat counter: clears on any key edge or when all keys are low. Fires first after HOLD_CYCLES, then every REPEAT_CYCLES, for the highest-priority held key.
- Target:
  - up is y-1, down is y+1, left is x-1, right is x+1.
  - Targets are formed with a 5-bit signed check. A target outside 0..MAP_WIDTH-1 or 0..MAP_HEIGHT-1 is dropped silently, with no request.
- Dead player: when health == 0, all key activity is ignored.
- FSM states: IDLE, ASK, WAIT.
  - IDLE to ASK: valid in-bounds request. Latch player_ask_x/y.
  - ASK to WAIT: unconditional. player_ask_move is high during ASK only.
  - WAIT to IDLE on accept_move: commit goto_x/y, floor_in, key_num_in and health_in on that edge.
  - WAIT to IDLE when the timeout counter reaches TIMEOUT_CYCLES: no commit, pulse move_timeout.
- Key edges and repeat ticks arriving while busy are discarded, not queued.
- accept_move seen in IDLE or ASK is ignored.
- player_x/y, floor, key_num and health change only on a WAIT-state accept, or at reset.

## Timing
- Reset values:
  - state IDLE; player_ask_move 0; player_ask_x/y equal START_X/START_Y.
  - player_x/y, floor, key_num and health equal their START_* parameters.
  - busy 0; move_timeout 0; repeat and timeout counters 0; key history 0.
- Reset mid-request abandons the request immediately, with no commit.
- Key rising edge sampled at edge 0:
  - player_ask_move high after edge 1.
  - Interaction stage asserts accept_move after edge 4.
  - Committed state visible after edge 5.
  - Earliest next request pulse is after edge 6.
- player_ask_x/y and all committed outputs are stable from the request pulse until commit. The interaction stage depends on this because its result path is combinational on them.
- Timeout counter starts at 0 on entry to WAIT and increments each WAIT cycle.

## Structure
- MAP_WIDTH and MAP_HEIGHT come from the shared game-parameters include.
- Key-repeat logic (edge detect, priority encode, hold/repeat counter) is a natural sub-module: key_repeat. Its output is a one-cycle dir_valid plus a 2-bit dir.
- The direction encoding (UP=0, DOWN=1, LEFT=2, RIGHT=3) belongs in the shared game-parameters include.

## Test plan
- Reset at (6,11), pulse key_right for 1 cycle, bench accepts with goto=(7,11), health_in=990 -> exactly one ask pulse with ask=(7,11); player=(7,11), health=990 after edge 5.
- Player at x=0, press key_left -> no ask pulse, busy stays 0, state unchanged.
- Press key_up and key_left together at (6,11) -> single ask with ask=(6,10).
- Hold key_down, sim parameters HOLD=20/REPEAT=8, always accept -> ask pulses at edge 1, then after 20 and every 8 cycles, y incrementing to MAP_HEIGHT-1 then stopping.
- Bench never asserts accept_move -> move_timeout pulse 15 cycles after WAIT entry, player state unchanged, busy drops, next key accepted.
- Commit health_in=0, then press keys -> no further ask pulses. Assert rstn low mid-WAIT -> all outputs at START values.
